// File: rtl/reg_bus_reader_pkg.sv
// Shared constants for the register/bus fabric: default sizes, state encoding
// and the source codes reported on src_id.
package reg_bus_reader_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREGS_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [3:0] SRC_DIN  = 4'd8;
    localparam logic [3:0] SRC_G    = 4'd9;
    localparam logic [3:0] SRC_NONE = 4'd15;

endpackage

// File: rtl/reg_bus_reader_if.sv
// Bus/handshake bundle between the register fabric and the bus reader.
// bus_par exists only when REG_BUS_READER_PARITY_EN is defined.
interface reg_bus_reader_if
    import reg_bus_reader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF
);
    logic [NREGS*WIDTH-1:0] Rdata;
    logic [WIDTH-1:0]       DIN;
    logic [WIDTH-1:0]       G;
    logic [NREGS-1:0]       Rout;
    logic                   DINout;
    logic                   Gout;
    logic                   rd_req;
    logic                   rd_ack;
    logic [WIDTH-1:0]       BusWires;
    logic                   bus_valid;
    logic                   bus_err;
    logic [3:0]             src_id;
`ifdef REG_BUS_READER_PARITY_EN
    logic                   bus_par;
`endif

    modport master (
        output Rdata, DIN, G, Rout, DINout, Gout, rd_req, rd_ack,
        input  BusWires, bus_valid, bus_err, src_id
`ifdef REG_BUS_READER_PARITY_EN
        , input bus_par
`endif
    );

    modport slave (
        input  Rdata, DIN, G, Rout, DINout, Gout, rd_req, rd_ack,
        output BusWires, bus_valid, bus_err, src_id
`ifdef REG_BUS_READER_PARITY_EN
        , output bus_par
`endif
    );

endinterface

// File: rtl/reg_bus_reader_bus_src_sel.sv
// Combinational source mux: picks the source named by the one-hot select,
// encodes its src_id and reports whether the select is legal (exactly one bit).
module bus_src_sel
    import reg_bus_reader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic [NREGS+1:0]       sel,
    input  logic [NREGS*WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0]       din,
    input  logic [WIDTH-1:0]       g,
    output logic [WIDTH-1:0]       data,
    output logic [3:0]             id,
    output logic                   legal
);

    logic [WIDTH-1:0] masked [NREGS+2];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg_mask
            assign masked[gi] = sel[gi] ? rdata[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    assign masked[NREGS]   = sel[NREGS]   ? din : '0;
    assign masked[NREGS+1] = sel[NREGS+1] ? g   : '0;

    // AND-OR mux; only meaningful when legal, which the caller checks.
    always_comb begin
        data = '0;
        id   = SRC_NONE;
        for (int k = 0; k < NREGS + 2; k++) begin
            data = data | masked[k];
            if (sel[k]) begin
                if (k == NREGS)
                    id = SRC_DIN;
                else if (k == NREGS + 1)
                    id = SRC_G;
                else
                    id = 4'(k);
            end
        end
    end

    assign legal = ($countones(sel) == 1);

endmodule

// File: rtl/reg_bus_reader.sv
// Read side of the register/bus fabric: captures the selected source on the
// rising edge and holds it under req/ack. Optional REG_BUS_READER_PARITY_EN adds bus_par.
module reg_bus_reader
    import reg_bus_reader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            Clock,
    input  logic            Resetn,
    reg_bus_reader_if.slave bus
);

    logic [NREGS+1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic [3:0]       sel_id;
    logic             sel_legal;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic [3:0]       src_q, src_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
`ifdef REG_BUS_READER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign sel = {bus.Gout, bus.DINout, bus.Rout};

    bus_src_sel #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_src_sel (
        .sel   (sel),
        .rdata (bus.Rdata),
        .din   (bus.DIN),
        .g     (bus.G),
        .data  (sel_data),
        .id    (sel_id),
        .legal (sel_legal)
    );

    // Reset is active-high despite the port name, matching the register blocks.
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state_q <= IDLE;
            bus_q   <= '0;
            src_q   <= SRC_NONE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef REG_BUS_READER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef REG_BUS_READER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.rd_req && sel_legal) state_d = HOLD;
            HOLD:    if (bus.rd_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack in HOLD takes priority; a simultaneous request waits for IDLE.
    always_comb begin
        bus_d   = bus_q;
        src_d   = src_q;
        valid_d = valid_q;
        err_d   = 1'b0;
`ifdef REG_BUS_READER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (bus.rd_req) begin
                    if (sel_legal) begin
                        bus_d   = sel_data;
                        src_d   = sel_id;
                        valid_d = 1'b1;
`ifdef REG_BUS_READER_PARITY_EN
                        par_d   = ^sel_data;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.rd_ack) begin
                    valid_d = 1'b0;
                    src_d   = SRC_NONE;
                end
            end
            default: ;
        endcase
    end

    assign bus.BusWires  = bus_q;
    assign bus.src_id    = src_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_err   = err_q;
`ifdef REG_BUS_READER_PARITY_EN
    assign bus.bus_par   = par_q;
`endif

endmodule
